fetch_unit: RTL



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the decode/control unit.
//   - Opcode encodings found in instr[6:0].
//   - Fetch FSM state encoding.
//   - Default instruction/address widths.
package cpu_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int ADDR_W_DEF  = 16;

  localparam logic [6:0] OP_LD  = 7'h00;
  localparam logic [6:0] OP_BEQ = 7'h0B;
  localparam logic [6:0] OP_BNE = 7'h0C;
  localparam logic [6:0] OP_JMP = 7'h0D;
  localparam logic [6:0] OP_LLI = 7'h0F;

  // BOOT: one idle cycle after reset. RUN: normal fetch.
  // DRAIN: stale responses from before a redirect are still outstanding.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO holding {pc, instr} entries.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           empty the FIFO this cycle (wins over push)
//   push, wdata     write an entry
//   pop, rdata      advance the head; rdata is the head entry
//   count           number of valid entries
//   full, empty     status flags
// A push and a pop in the same cycle leave count unchanged, including when
// the FIFO is full (the popped slot is rewritten).
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign rdata  = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity,
  // so the array maps onto plain registers/RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the opcode decoder.
// Owns the PC, issues word reads over a valid/ready request channel, takes
// in-order responses, buffers them with their PC and presents them to decode.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  fetch request channel
//   imem_rsp_valid, imem_rsp_data    in-order response channel
//   instr_valid/ready, instr_data,
//   instr_pc, opcode                 head of the instruction buffer to decode
//   redirect_en, redirect_pc         taken branch/jump from execute
// Optional build macro FETCH_PERF_CNT_EN adds stall_cnt (cycles in RUN with
// nothing to decode) and flush_cnt (accepted redirects), both saturating.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          INSTR_W  = INSTR_W_DEF,
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [6:0]         opcode,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [CW-1:0]     inflight_q, inflight_d, drop_q, drop_d, fifo_count;
  logic [CW:0]       occupancy;
  logic              fifo_full, fifo_empty;
  logic              redirect_take, active, issue, rsp, rsp_drop, push, pop;
  logic [EW-1:0]     fifo_rdata;

  // Tag queue: addresses of issued requests, popped in response order.
  logic [ADDR_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]     tag_wr, tag_rd;

  assign active        = (state_q == RUN) || (state_q == DRAIN);
  assign redirect_take = redirect_en && active;
  assign pop           = instr_valid && instr_ready;

  // Slots committed to in-flight requests plus buffered entries. A pop this
  // cycle frees a slot, which is what sustains one instruction per cycle.
  assign occupancy = (CW+1)'(inflight_q) + (CW+1)'(fifo_count) - (CW+1)'(pop);

  assign imem_req_valid = active && !redirect_en && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr      = pc_q;
  assign issue          = imem_req_valid && imem_req_ready;

  assign rsp      = imem_rsp_valid && (inflight_q != '0);
  assign rsp_drop = rsp && (drop_q != '0);
  // A redirect flushes the buffer, so the response arriving with it is lost.
  assign push     = rsp && !rsp_drop && !redirect_take && (!fifo_full || pop);

  assign inflight_d = inflight_q + CW'(issue) - CW'(rsp);

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (redirect_take)  drop_d = inflight_q - CW'(rsp);
    else if (rsp_drop)  drop_d = drop_q - CW'(1);
    unique case (state_q)
      BOOT:       state_d = RUN;
      RUN, DRAIN: state_d = (drop_d != '0) ? DRAIN : RUN;
      default:    state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= ADDR_W'(RESET_PC);
      inflight_q <= '0;
      drop_q     <= '0;
      tag_wr     <= '0;
      tag_rd     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (redirect_take) pc_q <= redirect_pc;
      else if (issue)    pc_q <= pc_q + ADDR_W'(1);
      if (issue) tag_wr <= tag_wr + PW'(1);
      if (rsp)   tag_rd <= tag_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr] <= pc_q;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_take),
    .push  (push),
    .wdata ({tag_mem[tag_rd], imem_rsp_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_pc    = fifo_rdata[EW-1:INSTR_W];
  assign instr_data  = fifo_rdata[INSTR_W-1:0];
  assign opcode      = fifo_rdata[6:0];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state_q == RUN) && !instr_valid && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect_take && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
